// File: rtl/lookup_pkg.sv
// Shared widths and record types for the lookup issuer and its response FIFO.
package lookup_pkg;
  localparam int LUT_ADDR_W = 8;
  localparam int LUT_DATA_W = 32;

  typedef struct packed {
    logic [LUT_ADDR_W-1:0] addr;
    logic [LUT_DATA_W-1:0] data;
  } lut_rsp_t;

  typedef struct packed {
    logic                  valid;
    logic [LUT_ADDR_W-1:0] addr;
  } lut_tag_t;
endpackage

// File: rtl/lookup_rsp_fifo.sv
// First-word-fall-through response FIFO; the head reads as zero while empty.
module lookup_rsp_fifo
  import lookup_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  lut_rsp_t         push_data_i,
  input  logic             pop_i,
  output lut_rsp_t         head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  lut_rsp_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/lookup_issuer.sv
// Issues lookups to a fixed-latency device, tracks them with a tag pipeline and
// collects the responses in a credit-protected FIFO.
module lookup_issuer
  import lookup_pkg::*;
#(
  parameter int LATENCY   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  cmd_valid,
  input  logic [LUT_ADDR_W-1:0] cmd_addr,
  output logic                  cmd_ready,
  output logic [LUT_ADDR_W-1:0] TIE_lut_Out,
  output logic                  TIE_lut_Out_Req,
  input  logic                  TIE_lut_Rdy,
  input  logic [LUT_DATA_W-1:0] TIE_lut_In,
  output logic                  rsp_valid,
  output logic [LUT_ADDR_W-1:0] rsp_addr,
  output logic [LUT_DATA_W-1:0] rsp_data,
  input  logic                  rsp_ready,
  output logic [15:0]           req_count
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int OCC_W = 6;

  lut_tag_t         tag_q [LATENCY];
  lut_tag_t         tag_d;
  logic             issue;
  logic [OCC_W-1:0] inflight;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] fifo_count;
  lut_rsp_t         capture;
  lut_rsp_t         head;
  logic [15:0]      req_count_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + OCC_W'(tag_q[i].valid);
  end

  // Credit counts every tag still travelling, so a capture always finds room.
  assign occupancy       = inflight + OCC_W'(fifo_count);
  assign cmd_ready       = RESET_N && TIE_lut_Rdy && (occupancy < OCC_W'(RSP_DEPTH));
  assign issue           = cmd_valid && cmd_ready;
  assign TIE_lut_Out_Req = issue;
  assign TIE_lut_Out     = issue ? cmd_addr : '0;

  always_comb begin
    tag_d       = '0;
    tag_d.valid = issue;
    tag_d.addr  = issue ? cmd_addr : '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      req_count_q <= '0;
    end else if (issue && (req_count_q != 16'hFFFF)) begin
      req_count_q <= req_count_q + 16'd1;
    end
  end

  assign capture.addr = tag_q[LATENCY-1].addr;
  assign capture.data = TIE_lut_In;

  lookup_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i       (CLK),
    .rst_ni      (RESET_N),
    .push_i      (tag_q[LATENCY-1].valid),
    .push_data_i (capture),
    .pop_i       (rsp_ready),
    .head_o      (head),
    .valid_o     (rsp_valid),
    .count_o     (fifo_count)
  );

  assign rsp_addr  = head.addr;
  assign rsp_data  = head.data;
  assign req_count = req_count_q;

endmodule

// File: tb/tb_lookup_issuer.sv
// Directed bench: instance A at LATENCY=1, instance B at LATENCY=3, each with a device model.
module tb_lookup_issuer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_cmd_valid, a_cmd_ready, a_out_req, a_rdy, a_rsp_valid, a_rsp_ready;
  logic [7:0]  a_cmd_addr, a_out, a_rsp_addr;
  logic [31:0] a_lut_in, a_rsp_data;
  logic [15:0] a_req_count;
  logic        b_cmd_valid, b_cmd_ready, b_out_req, b_rdy, b_rsp_valid, b_rsp_ready;
  logic [7:0]  b_cmd_addr, b_out, b_rsp_addr;
  logic [31:0] b_lut_in, b_rsp_data;
  logic [15:0] b_req_count;

  lookup_issuer #(.LATENCY(1), .RSP_DEPTH(4)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .cmd_valid(a_cmd_valid), .cmd_addr(a_cmd_addr),
    .cmd_ready(a_cmd_ready), .TIE_lut_Out(a_out), .TIE_lut_Out_Req(a_out_req),
    .TIE_lut_Rdy(a_rdy), .TIE_lut_In(a_lut_in), .rsp_valid(a_rsp_valid),
    .rsp_addr(a_rsp_addr), .rsp_data(a_rsp_data), .rsp_ready(a_rsp_ready),
    .req_count(a_req_count)
  );

  lookup_issuer #(.LATENCY(3), .RSP_DEPTH(4)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .cmd_valid(b_cmd_valid), .cmd_addr(b_cmd_addr),
    .cmd_ready(b_cmd_ready), .TIE_lut_Out(b_out), .TIE_lut_Out_Req(b_out_req),
    .TIE_lut_Rdy(b_rdy), .TIE_lut_In(b_lut_in), .rsp_valid(b_rsp_valid),
    .rsp_addr(b_rsp_addr), .rsp_data(b_rsp_data), .rsp_ready(b_rsp_ready),
    .req_count(b_req_count)
  );

  function automatic logic [31:0] dev_data(input logic [7:0] ad);
    case (ad)
      8'h00:   return 32'hFACEF00D;
      8'h11:   return 32'hCAFEBABE;
      8'h22:   return 32'h22222222;
      8'h32:   return 32'h12345678;
      8'h33:   return 32'h33333333;
      8'h77:   return 32'h77777777;
      8'hBB:   return 32'hBBBBBBBB;
      8'hDD:   return 32'hDDDDDDDD;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Device models: answer LATENCY cycles after the request strobe.
  logic       a_dev_v = 1'b0;
  logic [7:0] a_dev_addr = 8'h00;
  logic       b_dev_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] b_dev_addr [3] = '{8'h00, 8'h00, 8'h00};

  always @(posedge clk) begin
    a_dev_v       <= a_out_req;
    a_dev_addr    <= a_out;
    b_dev_v[0]    <= b_out_req;
    b_dev_addr[0] <= b_out;
    b_dev_v[1]    <= b_dev_v[0];
    b_dev_addr[1] <= b_dev_addr[0];
    b_dev_v[2]    <= b_dev_v[1];
    b_dev_addr[2] <= b_dev_addr[1];
  end

  assign a_lut_in = a_dev_v ? dev_data(a_dev_addr) : 32'h0;
  assign b_lut_in = b_dev_v[2] ? dev_data(b_dev_addr[2]) : 32'h0;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } rsp_t;

  rsp_t a_rq[$];
  rsp_t b_rq[$];
  int   a_iq[$];
  int   b_iq[$];

  always @(negedge clk) begin
    if (a_out_req) a_iq.push_back(cyc);
    if (b_out_req) b_iq.push_back(cyc);
    if (a_rsp_valid && a_rsp_ready) begin
      a_rq.push_back('{cyc, a_rsp_addr, a_rsp_data});
      $display("[%0d] A rsp addr=%h data=%h", cyc, a_rsp_addr, a_rsp_data);
    end
    if (b_rsp_valid && b_rsp_ready) begin
      b_rq.push_back('{cyc, b_rsp_addr, b_rsp_data});
      $display("[%0d] B rsp addr=%h data=%h", cyc, b_rsp_addr, b_rsp_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_cmd_valid = 1'b1; a_cmd_addr = 8'h5A; a_rdy = 1'b1; a_rsp_ready = 1'b1;
    b_cmd_valid = 1'b0; b_cmd_addr = 8'h00; b_rdy = 1'b1; b_rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (a_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 0", a_cmd_ready); end
    n_checks++; if (a_out_req !== 1'b0) begin n_fail++; $display("FAIL reset_out_req got %b exp 0", a_out_req); end
    n_checks++; if (a_out !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h exp 00", a_out); end
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", a_rsp_valid); end
    n_checks++; if (a_rsp_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_addr got %h exp 00", a_rsp_addr); end
    n_checks++; if (a_rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", a_rsp_data); end
    n_checks++; if (a_req_count !== 16'h0) begin n_fail++; $display("FAIL reset_req_count got %h exp 0", a_req_count); end
    n_checks++; if (b_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_cmd_ready got %b exp 0", b_cmd_ready); end
    tick();
    rst_n = 1'b1; a_cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready got %b exp 1", a_cmd_ready); end
    tick();
  endtask

  task automatic test_single();
    a_rq.delete(); a_iq.delete();
    a_cmd_valid = 1'b1; a_cmd_addr = 8'h11;
    @(negedge clk);
    n_checks++; if (a_out_req !== 1'b1) begin n_fail++; $display("FAIL single_out_req got %b exp 1", a_out_req); end
    n_checks++; if (a_out !== 8'h11) begin n_fail++; $display("FAIL single_out got %h exp 11", a_out); end
    tick();
    a_cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_out !== 8'h00) begin n_fail++; $display("FAIL idle_out got %h exp 00", a_out); end
    for (int i = 0; i < 20 && a_rq.size() < 1; i++) tick();
    n_checks++;
    if (a_rq.size() < 1) begin
      n_fail++; $display("FAIL single_timeout got %0d rsp exp 1", a_rq.size());
    end else begin
      n_checks++; if (a_rq[0].addr !== 8'h11) begin n_fail++; $display("FAIL single_addr got %h exp 11", a_rq[0].addr); end
      n_checks++; if (a_rq[0].data !== 32'hCAFEBABE) begin n_fail++; $display("FAIL single_data got %h exp CAFEBABE", a_rq[0].data); end
      n_checks++; if (a_rq[0].cyc - a_iq[0] != 2) begin n_fail++; $display("FAIL single_latency got %0d exp 2", a_rq[0].cyc - a_iq[0]); end
    end
    n_checks++; if (a_req_count !== 16'd1) begin n_fail++; $display("FAIL single_req_count got %0d exp 1", a_req_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ad [4];
    logic [31:0] ex [4];
    ad = '{8'h33, 8'h77, 8'hBB, 8'h32};
    ex = '{32'h33333333, 32'h77777777, 32'hBBBBBBBB, 32'h12345678};
    a_rq.delete(); a_iq.delete();
    for (int k = 0; k < 4; k++) begin
      a_cmd_valid = 1'b1; a_cmd_addr = ad[k];
      @(negedge clk);
      n_checks++; if (a_out_req !== 1'b1) begin n_fail++; $display("FAIL burst_out_req[%0d] got %b exp 1", k, a_out_req); end
      tick();
    end
    a_cmd_valid = 1'b0;
    for (int i = 0; i < 20 && a_rq.size() < 4; i++) tick();
    n_checks++;
    if (a_rq.size() < 4) begin
      n_fail++; $display("FAIL burst_timeout got %0d rsp exp 4", a_rq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (a_rq[k].data !== ex[k] || a_rq[k].addr !== ad[k]) begin
          n_fail++; $display("FAIL burst_rsp[%0d] got %h/%h exp %h/%h", k, a_rq[k].addr, a_rq[k].data, ad[k], ex[k]);
        end
        n_checks++; if (a_rq[k].cyc != a_iq[0] + 2 + k) begin
          n_fail++; $display("FAIL burst_timing[%0d] got cyc %0d exp %0d", k, a_rq[k].cyc, a_iq[0] + 2 + k);
        end
      end
    end
    n_checks++; if (a_req_count !== 16'd5) begin n_fail++; $display("FAIL burst_req_count got %0d exp 5", a_req_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ad [6];
    int k;
    ad = '{8'h33, 8'h77, 8'hBB, 8'h32, 8'h11, 8'h22};
    k = 0;
    a_rq.delete(); a_iq.delete();
    a_rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a_cmd_valid = 1'b1; a_cmd_addr = ad[(k < 6) ? k : 5];
      @(negedge clk);
      if (a_out_req === 1'b1) k++;
      tick();
    end
    @(negedge clk);
    n_checks++; if (k != 4) begin n_fail++; $display("FAIL bp_issue_count got %0d exp 4", k); end
    n_checks++; if (a_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready got %b exp 0", a_cmd_ready); end
    n_checks++; if (a_rsp_valid !== 1'b1 || a_rsp_addr !== 8'h33 || a_rsp_data !== 32'h33333333) begin
      n_fail++; $display("FAIL bp_head_hold got %b/%h/%h exp 1/33/33333333", a_rsp_valid, a_rsp_addr, a_rsp_data);
    end
    tick();
    a_cmd_valid = 1'b0; a_rsp_ready = 1'b1;
    for (int i = 0; i < 20 && a_rq.size() < 4; i++) tick();
    n_checks++;
    if (a_rq.size() != 4) begin
      n_fail++; $display("FAIL bp_drain_count got %0d exp 4", a_rq.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++; if (a_rq[j].addr !== ad[j] || a_rq[j].data !== dev_data(ad[j])) begin
          n_fail++; $display("FAIL bp_rsp[%0d] got %h/%h exp %h/%h", j, a_rq[j].addr, a_rq[j].data, ad[j], dev_data(ad[j]));
        end
      end
    end
    n_checks++; if (a_req_count !== 16'd9) begin n_fail++; $display("FAIL bp_req_count got %0d exp 9", a_req_count); end
  endtask

  task automatic test_rdy_gap();
    logic [7:0]  ad [5];
    logic [31:0] ex [5];
    int k;
    ad = '{8'h11, 8'h22, 8'h33, 8'h77, 8'hBB};
    ex = '{32'hCAFEBABE, 32'h22222222, 32'h33333333, 32'h77777777, 32'hBBBBBBBB};
    k = 0;
    a_rq.delete(); a_iq.delete();
    for (int c = 0; c < 10; c++) begin
      a_rdy = !(c >= 2 && c <= 4);
      a_cmd_valid = (k < 5); a_cmd_addr = ad[(k < 5) ? k : 4];
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        n_checks++; if (a_out_req !== 1'b0) begin n_fail++; $display("FAIL gap_out_req[%0d] got %b exp 0", c, a_out_req); end
      end
      if (a_out_req === 1'b1) k++;
      tick();
    end
    a_rdy = 1'b1; a_cmd_valid = 1'b0;
    n_checks++; if (k != 5) begin n_fail++; $display("FAIL gap_issue_count got %0d exp 5", k); end
    for (int i = 0; i < 20 && a_rq.size() < 5; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (a_rq.size() != 5) begin
      n_fail++; $display("FAIL gap_rsp_count got %0d exp 5", a_rq.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        n_checks++; if (a_rq[j].addr !== ad[j] || a_rq[j].data !== ex[j]) begin
          n_fail++; $display("FAIL gap_rsp[%0d] got %h/%h exp %h/%h", j, a_rq[j].addr, a_rq[j].data, ad[j], ex[j]);
        end
      end
    end
    n_checks++; if (a_req_count !== 16'd14) begin n_fail++; $display("FAIL gap_req_count got %0d exp 14", a_req_count); end
  endtask

  task automatic test_mid_reset();
    a_rq.delete(); a_iq.delete();
    a_cmd_valid = 1'b1; a_cmd_addr = 8'hDD;
    @(negedge clk);
    n_checks++; if (a_out_req !== 1'b1) begin n_fail++; $display("FAIL mr_issue got %b exp 1", a_out_req); end
    tick();
    rst_n = 1'b0; a_cmd_valid = 1'b1; a_cmd_addr = 8'h44;
    @(negedge clk);
    n_checks++; if (a_cmd_ready !== 1'b0 || a_out_req !== 1'b0 || a_out !== 8'h00) begin
      n_fail++; $display("FAIL mr_cmd_side got %b/%b/%h exp 0/0/00", a_cmd_ready, a_out_req, a_out);
    end
    n_checks++; if (a_rsp_valid !== 1'b0 || a_rsp_addr !== 8'h00 || a_rsp_data !== 32'h0) begin
      n_fail++; $display("FAIL mr_rsp_side got %b/%h/%h exp 0/00/0", a_rsp_valid, a_rsp_addr, a_rsp_data);
    end
    n_checks++; if (a_req_count !== 16'h0) begin n_fail++; $display("FAIL mr_req_count got %0d exp 0", a_req_count); end
    tick();
    rst_n = 1'b1; a_cmd_valid = 1'b1; a_cmd_addr = 8'h22;
    @(negedge clk);
    n_checks++; if (a_out_req !== 1'b1) begin n_fail++; $display("FAIL mr_first_issue got %b exp 1", a_out_req); end
    tick();
    a_cmd_valid = 1'b0;
    for (int i = 0; i < 20 && a_rq.size() < 1; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (a_rq.size() != 1) begin
      n_fail++; $display("FAIL mr_rsp_count got %0d exp 1", a_rq.size());
    end else begin
      n_checks++; if (a_rq[0].addr !== 8'h22 || a_rq[0].data !== 32'h22222222) begin
        n_fail++; $display("FAIL mr_rsp got %h/%h exp 22/22222222", a_rq[0].addr, a_rq[0].data);
      end
    end
    n_checks++; if (a_req_count !== 16'd1) begin n_fail++; $display("FAIL mr_req_count_after got %0d exp 1", a_req_count); end
  endtask

  task automatic test_latency3();
    logic [7:0]  ad [2];
    logic [31:0] ex [2];
    ad = '{8'h00, 8'h05};
    ex = '{32'hFACEF00D, 32'hDEADBEEF};
    b_rq.delete(); b_iq.delete();
    for (int k = 0; k < 2; k++) begin
      b_cmd_valid = 1'b1; b_cmd_addr = ad[k];
      @(negedge clk);
      n_checks++; if (b_out_req !== 1'b1) begin n_fail++; $display("FAIL lat3_issue[%0d] got %b exp 1", k, b_out_req); end
      tick();
    end
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 30 && b_rq.size() < 2; i++) tick();
    n_checks++;
    if (b_rq.size() < 2 || b_iq.size() < 2) begin
      n_fail++; $display("FAIL lat3_timeout got %0d rsp exp 2", b_rq.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (b_rq[k].addr !== ad[k] || b_rq[k].data !== ex[k]) begin
          n_fail++; $display("FAIL lat3_rsp[%0d] got %h/%h exp %h/%h", k, b_rq[k].addr, b_rq[k].data, ad[k], ex[k]);
        end
        n_checks++; if (b_rq[k].cyc - b_iq[k] != 4) begin
          n_fail++; $display("FAIL lat3_latency[%0d] got %0d exp 4", k, b_rq[k].cyc - b_iq[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_rdy_gap();
    test_mid_reset();
    test_latency3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
